// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared encodings and helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } lsu_state_e;

    localparam logic [1:0] MEM_TRIM_WORD = 2'b00;
    localparam logic [1:0] MEM_TRIM_HALF = 2'b01;
    localparam logic [1:0] MEM_TRIM_BYTE = 2'b10;

    localparam logic [3:0] STORE_MASK_NONE = 4'b0000;
    localparam logic [3:0] STORE_MASK_BYTE = 4'b0001;
    localparam logic [3:0] STORE_MASK_HALF = 4'b0011;
    localparam logic [3:0] STORE_MASK_WORD = 4'b1111;

    // Access size is carried in trim encoding for both loads and stores.
    function automatic logic [3:0] size_mask(input logic [1:0] trim);
        case (trim)
            MEM_TRIM_BYTE: size_mask = STORE_MASK_BYTE;
            MEM_TRIM_HALF: size_mask = STORE_MASK_HALF;
            default:       size_mask = STORE_MASK_WORD;
        endcase
    endfunction

    function automatic logic [31:0] replicate_wdata(input logic [1:0] trim, input logic [31:0] wdata);
        case (trim)
            MEM_TRIM_BYTE: replicate_wdata = {4{wdata[7:0]}};
            MEM_TRIM_HALF: replicate_wdata = {2{wdata[15:0]}};
            default:       replicate_wdata = wdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half lane of a bus word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  trim_i,
    input  logic        sext_i,
    output logic [31:0] result_o
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_shift = rdata_i >> {addr_lo_i, 3'b000};
    assign half_shift = rdata_i >> {addr_lo_i[1], 4'b0000};
    assign byte_sel   = byte_shift[7:0];
    assign half_sel   = half_shift[15:0];

    always_comb begin
        result_o = rdata_i;
        case (trim_i)
            MEM_TRIM_BYTE: result_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
            MEM_TRIM_HALF: result_o = {{16{sext_i & half_sel[15]}}, half_sel};
            default:       result_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage req/gnt/rvalid bus master with alignment and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic [3:0]        mem_write_i,
    input  logic [1:0]        mem_trim_i,
    input  logic              mem_sign_extend_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              misaligned_o,
    output logic              bus_err_o,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output logic [3:0]        dbus_be_o,
    output logic [31:0]       dbus_wdata_o,
    input  logic              dbus_gnt_i,
    input  logic              dbus_rvalid_i,
    input  logic [31:0]       dbus_rdata_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [1:0]        trim_q, trim_d;
    logic              sext_q, sext_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              misaligned_q, misaligned_d;
    logic              bus_err_q, bus_err_d;

    logic        acc;
    logic [1:0]  req_trim;
    logic        misaligned;
    logic        timed_out;
    logic [31:0] load_data;

    assign acc      = mem_read_i | (|mem_write_i);
    assign req_trim = mem_read_i    ? mem_trim_i    :
                      mem_write_i[3] ? MEM_TRIM_WORD :
                      mem_write_i[1] ? MEM_TRIM_HALF : MEM_TRIM_BYTE;

    // Trim 2'b11 is treated as a word access throughout.
    assign misaligned = ((req_trim == MEM_TRIM_HALF) && addr_i[0]) ||
                        ((req_trim != MEM_TRIM_HALF) && (req_trim != MEM_TRIM_BYTE) && (addr_i[1:0] != 2'b00));

    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    load_align u_load_align (
        .rdata_i   (dbus_rdata_i),
        .addr_lo_i (addr_q[1:0]),
        .trim_i    (trim_q),
        .sext_i    (sext_q),
        .result_o  (load_data)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        trim_d        = trim_q;
        sext_d        = sext_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        misaligned_d  = misaligned_q;
        bus_err_d     = bus_err_q;
        stall_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    stall_o = 1'b1;
                    if (misaligned) begin
                        misaligned_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        addr_d  = addr_i;
                        be_d    = size_mask(req_trim) << addr_i[1:0];
                        wdata_d = replicate_wdata(req_trim, wdata_i);
                        we_d    = ~mem_read_i;
                        trim_d  = req_trim;
                        sext_d  = mem_sign_extend_i;
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_o = 1'b1;
                if (dbus_gnt_i) begin
                    cnt_d   = '0;
                    state_d = we_q ? ST_DONE : ST_WAIT_RD;
                end else if (timed_out) begin
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_RD: begin
                stall_o = 1'b1;
                if (dbus_rvalid_i) begin
                    rdata_d       = load_data;
                    rdata_valid_d = 1'b1;
                    state_d       = ST_DONE;
                end else if (timed_out) begin
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // Result stays visible until the pipeline is free to consume it.
                if (!hold_i) begin
                    rdata_d       = '0;
                    rdata_valid_d = 1'b0;
                    misaligned_d  = 1'b0;
                    bus_err_d     = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            trim_q        <= MEM_TRIM_WORD;
            sext_q        <= 1'b0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            trim_q        <= trim_d;
            sext_q        <= sext_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            misaligned_q  <= misaligned_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign dbus_req_o    = (state_q == ST_REQ);
    assign dbus_we_o     = we_q;
    assign dbus_addr_o   = {addr_q[ADDR_W-1:2], 2'b00};
    assign dbus_be_o     = be_q;
    assign dbus_wdata_o  = wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign misaligned_o  = misaligned_q;
    assign bus_err_o     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a scripted bus slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst_i = 1'b1;
    logic        mem_read_i = 1'b0;
    logic [3:0]  mem_write_i = 4'b0000;
    logic [1:0]  mem_trim_i = 2'b00;
    logic        mem_sign_extend_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        hold_i = 1'b0;
    logic        stall_o, rdata_valid_o, misaligned_o, bus_err_o;
    logic [31:0] rdata_o;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_gnt_i, dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;

    load_store_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_trim_i(mem_trim_i),
        .mem_sign_extend_i(mem_sign_extend_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .hold_i(hold_i), .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        valid;
        logic        mis;
        logic        err;
        int          stall_cycles;
    } res_exp_t;

    bus_exp_t bus_q[$];
    res_exp_t res_q[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          gnt_delay = 0;
    bit          rv_enable = 1'b1;
    logic [31:0] rdata_resp = 32'h0;
    int          inject_at = -1;
    bit          done_flag = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus slave: grants after gnt_delay request cycles, answers reads one cycle later.
    initial begin
        int req_cycles;
        bit rd_pending;
        req_cycles = 0;
        rd_pending = 1'b0;
        dbus_gnt_i = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            dbus_gnt_i = 1'b0;
            dbus_rvalid_i = 1'b0;
            dbus_rdata_i = 32'h0BAD_0BAD;
            if (rst_i) begin
                req_cycles = 0;
                rd_pending = 1'b0;
            end else begin
                if (rd_pending) begin
                    dbus_rvalid_i = 1'b1;
                    dbus_rdata_i = rdata_resp;
                    rd_pending = 1'b0;
                end
                if (cyc == inject_at) begin
                    dbus_rvalid_i = 1'b1;
                    dbus_rdata_i = 32'h1234_5678;
                end
                if (dbus_req_o) begin
                    if (req_cycles == gnt_delay) begin
                        dbus_gnt_i = 1'b1;
                        req_cycles = 0;
                        rd_pending = !dbus_we_o && rv_enable;
                    end else begin
                        req_cycles++;
                    end
                end else begin
                    req_cycles = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares bus handshakes and completions against the queues.
    initial begin
        bit          started;
        bit          prev_stall, prev_hold, prev_req;
        int          stall_cnt;
        logic [31:0] last_rdata;
        logic [68:0] prev_bus;
        bus_exp_t    be_exp;
        res_exp_t    re_exp;
        started = 1'b0; prev_stall = 1'b0; prev_hold = 1'b0; prev_req = 1'b0;
        stall_cnt = 0; last_rdata = 32'h0; prev_bus = '0;
        forever begin
            @(negedge clk);
            #2;
            if (done_flag) begin
                chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
                chk("result_queue_drained", 64'(res_q.size()), 64'd0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (!started) begin
                if (rst_i) continue;
                started = 1'b1;
                chk("reset_ctrl", {58'd0, stall_o, dbus_req_o, dbus_we_o, rdata_valid_o, misaligned_o, bus_err_o}, 64'd0);
                chk("reset_rdata", {32'd0, rdata_o}, 64'd0);
                chk("reset_bus", {dbus_addr_o, dbus_be_o, 28'd0}, 64'd0);
                chk("reset_wdata", {32'd0, dbus_wdata_o}, 64'd0);
            end
            if (dbus_req_o && dbus_gnt_i) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_req", {32'd0, dbus_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    be_exp = bus_q.pop_front();
                    chk("bus_addr", {32'd0, dbus_addr_o}, {32'd0, be_exp.addr});
                    chk("bus_be", {60'd0, dbus_be_o}, {60'd0, be_exp.be});
                    chk("bus_we", {63'd0, dbus_we_o}, {63'd0, be_exp.we});
                    chk("bus_wdata", {32'd0, dbus_wdata_o}, {32'd0, be_exp.wdata});
                end
            end
            if (dbus_req_o && prev_req)
                chk("req_stable", {27'd0, dbus_addr_o, dbus_be_o, dbus_we_o}, {27'd0, prev_bus[68:32]});
            if (!stall_o && prev_stall) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_completion", 64'(stall_cnt), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    re_exp = res_q.pop_front();
                    chk("result_rdata", {32'd0, rdata_o}, {32'd0, re_exp.rdata});
                    chk("result_flags", {61'd0, rdata_valid_o, misaligned_o, bus_err_o},
                        {61'd0, re_exp.valid, re_exp.mis, re_exp.err});
                    chk("stall_cycles", 64'(stall_cnt), 64'(re_exp.stall_cycles));
                    last_rdata = re_exp.rdata;
                end
            end else if (!stall_o && !prev_stall && hold_i && !rst_i) begin
                chk("hold_rdata", {32'd0, rdata_o}, {32'd0, last_rdata});
                chk("hold_no_reissue", {62'd0, dbus_req_o, rdata_valid_o}, 64'd1);
            end else if (!stall_o && !prev_stall && !hold_i && !prev_hold && !rst_i) begin
                chk("idle_quiet", {28'd0, rdata_o, rdata_valid_o, misaligned_o, bus_err_o, dbus_req_o},
                    64'd0);
            end
            stall_cnt  = stall_o ? stall_cnt + 1 : 0;
            prev_stall = stall_o;
            prev_hold  = hold_i;
            prev_req   = dbus_req_o;
            prev_bus   = {dbus_addr_o, dbus_be_o, dbus_we_o, dbus_wdata_o};
        end
    end

    task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
        bus_exp_t e;
        e.addr = a; e.be = be; e.we = we; e.wdata = wd;
        bus_q.push_back(e);
    endtask

    task automatic push_res(input logic [31:0] rd, input logic v, input logic m, input logic er, input int sc);
        res_exp_t e;
        e.rdata = rd; e.valid = v; e.mis = m; e.err = er; e.stall_cycles = sc;
        res_q.push_back(e);
    endtask

    // Presents one instruction, holds it while stalled, then retires it.
    task automatic issue(input bit rd, input logic [3:0] wr, input logic [1:0] trim, input bit sx,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
        @(posedge clk);
        #1;
        mem_read_i = rd; mem_write_i = wr; mem_trim_i = trim; mem_sign_extend_i = sx;
        addr_i = a; wdata_i = wd; hold_i = hold;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!stall_o) break;
        end
        @(posedge clk);
        #1;
        mem_read_i = 1'b0; mem_write_i = 4'b0000; mem_trim_i = 2'b00; mem_sign_extend_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk);

        push_bus(32'h104, 4'b1111, 1'b1, 32'hDEADBEEF); push_res(32'h0, 0, 0, 0, 2);
        issue(0, 4'b1111, 2'b00, 0, 32'h104, 32'hDEADBEEF, 0);
        push_bus(32'h200, 4'b1000, 1'b1, 32'hA5A5A5A5); push_res(32'h0, 0, 0, 0, 2);
        issue(0, 4'b0001, 2'b00, 0, 32'h203, 32'h000000A5, 0);
        push_bus(32'h500, 4'b1100, 1'b1, 32'h12341234); push_res(32'h0, 0, 0, 0, 2);
        issue(0, 4'b0011, 2'b00, 0, 32'h502, 32'h00001234, 0);

        gnt_delay = 3; rdata_resp = 32'h0000F000;
        push_bus(32'h300, 4'b0010, 1'b0, 32'h0); push_res(32'hFFFFFFF0, 1, 0, 0, 6);
        issue(1, 4'b0000, 2'b10, 1, 32'h301, 32'h0, 0);
        gnt_delay = 0;
        push_bus(32'h300, 4'b0010, 1'b0, 32'h0); push_res(32'h000000F0, 1, 0, 0, 3);
        issue(1, 4'b0000, 2'b10, 0, 32'h301, 32'h0, 0);

        rdata_resp = 32'h80010000;
        push_bus(32'h600, 4'b1100, 1'b0, 32'h0); push_res(32'hFFFF8001, 1, 0, 0, 3);
        issue(1, 4'b0000, 2'b01, 1, 32'h602, 32'h0, 0);
        push_bus(32'h600, 4'b1100, 1'b0, 32'h0); push_res(32'h00008001, 1, 0, 0, 3);
        issue(1, 4'b0000, 2'b01, 0, 32'h602, 32'h0, 0);

        push_res(32'h0, 0, 1, 0, 1);
        issue(1, 4'b0000, 2'b01, 1, 32'h401, 32'h0, 0);
        push_res(32'h0, 0, 1, 0, 1);
        issue(0, 4'b1111, 2'b00, 0, 32'h106, 32'h11111111, 0);

        rv_enable = 1'b0; rdata_resp = 32'hFFFFFFFF;
        push_bus(32'h800, 4'b1111, 1'b0, 32'h0); push_res(32'h0, 0, 0, 1, 6);
        issue(1, 4'b0000, 2'b00, 0, 32'h800, 32'h0, 0);
        rv_enable = 1'b1; gnt_delay = 100;
        push_res(32'h0, 0, 0, 1, 5);
        issue(0, 4'b1111, 2'b00, 0, 32'h900, 32'h55555555, 0);
        gnt_delay = 0;

        rdata_resp = 32'hCAFEF00D;
        push_bus(32'h700, 4'b1111, 1'b0, 32'h0); push_res(32'hCAFEF00D, 1, 0, 0, 3);
        issue(1, 4'b0000, 2'b00, 0, 32'h700, 32'h0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        hold_i = 1'b0;
        repeat (2) @(posedge clk);

        // Reset while waiting for read data; the rvalid that follows must be dropped.
        rv_enable = 1'b0;
        push_bus(32'hA00, 4'b1111, 1'b0, 32'h0); push_res(32'h0, 0, 0, 0, 3);
        @(posedge clk); #1;
        mem_read_i = 1'b1; mem_trim_i = 2'b00; addr_i = 32'hA00;
        @(posedge clk);
        @(posedge clk); #1;
        rst_i = 1'b1;
        mem_read_i = 1'b0; addr_i = 32'h0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        inject_at = cyc + 1;
        repeat (4) @(posedge clk);
        rv_enable = 1'b1;

        push_bus(32'h104, 4'b1111, 1'b1, 32'h0BADF00D); push_res(32'h0, 0, 0, 0, 2);
        issue(0, 4'b1111, 2'b00, 0, 32'h104, 32'h0BADF00D, 0);
        repeat (3) @(posedge clk);
        done_flag = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
